// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the CPU inter-stage pipeline register:
//                field indices of the packed stage payload, default widths
//                and reset PC, and the occupancy encoding of the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Field positions inside the packed stage payload
    localparam int FLD_RDATA = 0;
    localparam int FLD_ALU   = 1;
    localparam int FLD_PC    = 2;
    localparam int FLD_INSTR = 3;
    localparam int FLD_LO    = 4;
    localparam int FLD_HI    = 5;

    localparam int          DEFAULT_DATA_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Number of payloads held by the stage; the value is driven on occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : valid/ready stream carrying one packed pipeline payload.
//                master drives valid/data and samples ready,
//                slave samples valid/data and drives ready.
//  Signals     : valid - payload is valid
//                ready - receiver accepts the payload this cycle
//                data  - NCH fields of DATA_W bits, field k at [k*DATA_W +: DATA_W]
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int NCH    = 6
) ();
    logic                    valid;
    logic                    ready;
    logic [NCH*DATA_W-1:0]   data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_entry.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_entry
//  Description : One valid + payload register of the pipeline stage.
//                clear  : invalidate and zero the payload (optionally keeping
//                         the PC field), highest priority
//                load   : capture load_data_i and mark valid
//                drop   : invalidate while keeping the payload unchanged
//  Ports       : clk, reset (async, active low), load_i, load_data_i, drop_i,
//                clear_i, keep_pc_i, valid_o, data_o
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                NCH      = 6,
    parameter int                PC_IDX   = FLD_PC,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  load_i,
    input  wire logic [NCH*DATA_W-1:0] load_data_i,
    input  wire logic                  drop_i,
    input  wire logic                  clear_i,
    input  wire logic                  keep_pc_i,
    output logic                       valid_o,
    output logic [NCH*DATA_W-1:0]      data_o
);
    localparam int                   c_W          = NCH * DATA_W;
    localparam logic [c_W-1:0]       c_RESET_DATA = c_W'(RESET_PC) << (PC_IDX * DATA_W);

    logic             valid_q, valid_d;
    logic [c_W-1:0]   data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            // The PC survives a flush so the exception PC can still be traced
            if (keep_pc_i) begin
                data_d[PC_IDX*DATA_W +: DATA_W] = data_q[PC_IDX*DATA_W +: DATA_W];
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= c_RESET_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_stage_entry
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Inter-stage pipeline register with a two-entry skid buffer
//                (main + skid) giving a registered in_ready, FIFO ordering,
//                1-cycle latency and a flush that inserts a zeroed bubble
//                (PC field of the main entry preserved).
//  Ports       : clk, reset (async, active low)
//                up   - upstream stream  (slave:  in_valid/in_ready/in_data)
//                dn   - downstream stream (master: out_valid/out_ready/out_data)
//                flush     - drop all held and incoming payloads
//                occupancy - number of held payloads (0..2)
//  Option      : PIPE_STAGE_PERF_EN adds stall_cnt / bubble_cnt counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                NCH      = 6,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC),
    parameter int                PC_IDX   = FLD_PC
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pipe_stage_reg_if.slave    up,
    pipe_stage_reg_if.master   dn,
    input  wire logic          flush,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt,
`endif
    output logic [1:0]         occupancy
);
    localparam int c_W = NCH * DATA_W;

    occ_e            occ_q;
    logic            in_ready_q;

    logic            w_main_valid, w_skid_valid;
    logic [c_W-1:0]  w_main_data,  w_skid_data;

    logic            w_acc, w_drn;
    logic            w_main_load, w_main_drop;
    logic            w_skid_load, w_skid_clear;
    logic [c_W-1:0]  w_main_src;

    assign w_acc = up.valid & in_ready_q;
    assign w_drn = w_main_valid & dn.ready;

    // Main is reloaded when it is empty, when it is drained while a new
    // payload arrives, or when the skid payload moves forward.
    assign w_main_load  = ~flush & ((w_acc & ((occ_q == OCC_EMPTY) | w_drn))
                                  | ((occ_q == OCC_FULL) & w_drn));
    assign w_main_drop  = ~flush & w_drn & ~w_main_load;
    assign w_main_src   = w_skid_valid ? w_skid_data : up.data;
    assign w_skid_load  = ~flush & w_acc & (occ_q == OCC_ONE) & ~w_drn;
    assign w_skid_clear = flush | ((occ_q == OCC_FULL) & w_drn);

    pipe_stage_entry #(
        .DATA_W   (DATA_W),
        .NCH      (NCH),
        .PC_IDX   (PC_IDX),
        .RESET_PC (RESET_PC)
    ) u_main (
        .clk         (clk),
        .reset       (reset),
        .load_i      (w_main_load),
        .load_data_i (w_main_src),
        .drop_i      (w_main_drop),
        .clear_i     (flush),
        .keep_pc_i   (1'b1),
        .valid_o     (w_main_valid),
        .data_o      (w_main_data)
    );

    pipe_stage_entry #(
        .DATA_W   (DATA_W),
        .NCH      (NCH),
        .PC_IDX   (PC_IDX),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .load_i      (w_skid_load),
        .load_data_i (up.data),
        .drop_i      (1'b0),
        .clear_i     (w_skid_clear),
        .keep_pc_i   (1'b0),
        .valid_o     (w_skid_valid),
        .data_o      (w_skid_data)
    );

    // Occupancy FSM; in_ready is a registered copy of (next occupancy != FULL)
    // so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (w_acc) occ_q <= OCC_ONE;
                end
                OCC_ONE: begin
                    if (w_acc && !w_drn) begin
                        occ_q      <= OCC_FULL;
                        in_ready_q <= 1'b0;
                    end else if (w_drn && !w_acc) begin
                        occ_q      <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_drn) begin
                        occ_q      <= OCC_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    occ_q      <= OCC_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign up.ready  = in_ready_q;
    assign dn.valid  = w_main_valid;
    assign dn.data   = w_main_data;
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, bubble_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (up.valid && !in_ready_q && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            // An idle downstream slot and a flush of live payloads both count
            // as a bubble; the two conditions are mutually exclusive.
            if (((!w_main_valid && dn.ready) || (flush && w_main_valid))
                && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. A queue-based model
//                (at most two payloads, FIFO, flush empties it) predicts
//                out_valid, out_data, in_ready, occupancy and, when
//                PIPE_STAGE_PERF_EN is defined, the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int          DW  = 32;
    localparam int          N   = 6;
    localparam int          W   = DW * N;
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int          PCI = FLD_PC;

    typedef logic [W-1:0] pl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_reg_if #(.DATA_W(DW), .NCH(N)) up_if ();
    pipe_stage_reg_if #(.DATA_W(DW), .NCH(N)) dn_if ();

    pipe_stage_reg #(
        .DATA_W   (DW),
        .NCH      (N),
        .RESET_PC (RPC),
        .PC_IDX   (PCI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .up         (up_if),
        .dn         (dn_if),
        .flush      (flush),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    pl_t         q[$];
    pl_t         out_exp;
    logic [31:0] stall_exp, bubble_exp;
    int          checks   = 0;
    int          failures = 0;

    function automatic pl_t rst_payload();
        pl_t p = '0;
        p[PCI*DW +: DW] = RPC;
        return p;
    endfunction

    function automatic pl_t mk(logic [31:0] instr);
        pl_t p;
        for (int k = 0; k < N; k++) p[k*DW +: DW] = $urandom;
        p[FLD_INSTR*DW +: DW] = instr;
        return p;
    endfunction

    function automatic logic [31:0] fld(pl_t p, int k);
        return p[k*DW +: DW];
    endfunction

    task automatic check(string tag, pl_t obs, pl_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        out_exp    = rst_payload();
        stall_exp  = '0;
        bubble_exp = '0;
    endtask

    task automatic check_all(string tag);
        check({tag, "_out_valid"}, pl_t'(dn_if.valid), pl_t'(q.size() > 0));
        check({tag, "_occupancy"}, pl_t'(occupancy),   pl_t'(q.size()));
        check({tag, "_in_ready"},  pl_t'(up_if.ready), pl_t'(q.size() < 2));
        check({tag, "_out_data"},  dn_if.data,         out_exp);
`ifdef PIPE_STAGE_PERF_EN
        check({tag, "_stall_cnt"},  pl_t'(stall_cnt),  pl_t'(stall_exp));
        check({tag, "_bubble_cnt"}, pl_t'(bubble_cnt), pl_t'(bubble_exp));
`endif
    endtask

    // One clock edge with the currently driven inputs, then model update and checks
    task automatic cycle(string tag);
        int  sz  = q.size();
        bit  acc = up_if.valid && (sz < 2);
        bit  drn = (sz > 0) && dn_if.ready;
        pl_t din = up_if.data;
        if (up_if.valid && sz == 2 && stall_exp != '1) stall_exp++;
        if (((sz == 0 && dn_if.ready) || (flush && sz > 0)) && bubble_exp != '1) bubble_exp++;
        @(posedge clk);
        if (flush) begin
            pl_t p = '0;
            p[PCI*DW +: DW] = out_exp[PCI*DW +: DW];
            out_exp = p;
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(din);
            if (q.size() > 0) out_exp = q[0];
        end
        #1;
        check_all(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        pl_t         pa, pb, pc, p1;
        logic [31:0] s0, b0;

        reset       = 1'b0;
        flush       = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        model_reset();

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_pc", pl_t'(fld(dn_if.data, PCI)), pl_t'(32'h0000_3000));
        reset = 1'b1;

        // Streaming, instr = 1..10 with out_ready held high
        dn_if.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            up_if.valid = 1'b1;
            up_if.data  = mk(32'(i));
            cycle("stream");
            check("stream_instr", pl_t'(fld(dn_if.data, FLD_INSTR)), pl_t'(i));
        end
        up_if.valid = 1'b0;
        cycle("stream_idle");

        // Back-pressure: A then B with out_ready low, then drain
        dn_if.ready = 1'b0;
        pa = mk(32'h1111_1111);
        pb = mk(32'h2222_2222);
        up_if.valid = 1'b1; up_if.data = pa; cycle("bp_pushA");
        up_if.data  = pb;                    cycle("bp_pushB");
        check("bp_full_occ", pl_t'(occupancy), pl_t'(2));
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        cycle("bp_drain1");
        check("bp_instr_B", pl_t'(fld(dn_if.data, FLD_INSTR)), pl_t'(32'h2222_2222));
        check("bp_ready_back", pl_t'(up_if.ready), pl_t'(1));
        cycle("bp_drain2");

        // Flush while FULL, with C offered in the same cycle
        dn_if.ready = 1'b0;
        p1 = mk(32'h4444_4444);
        up_if.valid = 1'b1; up_if.data = p1;                   cycle("fl_fill1");
        up_if.data  = mk(32'h5555_5555);                       cycle("fl_fill2");
        pc = mk(32'h3333_3333);
        up_if.data = pc;
        flush      = 1'b1;
        cycle("flush_full");
        flush       = 1'b0;
        up_if.valid = 1'b0;
        check("flush_instr", pl_t'(fld(dn_if.data, FLD_INSTR)), pl_t'(0));
        check("flush_pc", pl_t'(fld(dn_if.data, PCI)), pl_t'(fld(p1, PCI)));
        dn_if.ready = 1'b1;
        cycle("flush_after");
        check("flush_no_C", pl_t'(fld(dn_if.data, FLD_INSTR) == 32'h3333_3333), pl_t'(0));

`ifdef PIPE_STAGE_PERF_EN
        // Stall counting after FULL, then flush of two live payloads
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data = mk(32'h6666_6666); cycle("perf_fill1");
        up_if.data = mk(32'h7777_7777); cycle("perf_fill2");
        s0 = stall_exp;
        for (int i = 0; i < 5; i++) cycle("perf_stall");
        check("perf_stall5", pl_t'(stall_cnt), pl_t'(s0 + 32'd5));
        b0 = bubble_exp;
        flush = 1'b1;
        up_if.valid = 1'b0;
        cycle("perf_flush");
        flush = 1'b0;
        check("perf_bubble1", pl_t'(bubble_cnt), pl_t'(b0 + 32'd1));
`else
        s0 = '0;
        b0 = '0;
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            up_if.valid = ($urandom_range(3) != 0);
            up_if.data  = mk($urandom);
            dn_if.ready = ($urandom_range(2) != 0);
            flush       = ($urandom_range(24) == 0);
            cycle("rand");
        end
        flush = 1'b0;

        // Async reset between edges while one payload is held
        dn_if.ready = 1'b0;
        up_if.valid = 1'b0;
        flush = 1'b1;               cycle("ar_flush");
        flush = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = mk(32'h8888_8888);
        cycle("ar_load");
        up_if.valid = 1'b0;
        check("ar_occ1", pl_t'(occupancy), pl_t'(1));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        dn_if.ready = 1'b1;
        cycle("post_reset");
        check("post_reset_valid", pl_t'(dn_if.valid), pl_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the five-stage CPU (F/D, D/E, E/M, M/W boundaries). Carries NCH packed fields of DATA_W bits each, with per-stage valid and a valid/ready handshake in both directions. A two-entry skid buffer gives a registered in_ready, so stalls never form a combinational path. Supports flush, which inserts a zeroed bubble (instr=0 decodes as nop).

Parameters:
DATA_W, 32, width of one field
NCH, 6, number of fields per stage (e.g. ReadData, ALUOut, pc, instr, LO, HI)
RESET_PC, 32'h0000_3000, reset value loaded into field PC_IDX
PC_IDX, 2, field index that holds pc; all other fields reset to 0

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted = 0)
in_valid  in  1  upstream holds a valid stage payload
in_ready  out  1  block can accept a payload this cycle (registered)
in_data  in  NCH*DATA_W  packed fields; field k is bits [k*DATA_W +: DATA_W]
flush  in  1  discard all held payloads and any incoming payload
out_valid  out  1  out_data is a valid payload
out_ready  in  1  downstream consumes the payload this cycle
out_data  out  NCH*DATA_W  packed output fields (registered)
occupancy  out  2  number of held payloads: 0, 1 or 2

Behaviour:
- Reset (reset=0, async): main and skid entries invalid; all data fields 0 except field PC_IDX = RESET_PC; out_valid=0; in_ready=1; occupancy=0.
- Input transfer: in_valid & in_ready at a clock edge. Output transfer: out_valid & out_ready at a clock edge.
- Latency: 1 cycle. A payload accepted at edge N appears on out_data/out_valid after edge N when the main entry was empty or was drained at edge N.
- States, encoded by occupancy:
  EMPTY(0): accept -> ONE.
  ONE(1): accept & drain -> ONE (main takes the new payload); accept & no drain -> FULL (new payload goes to skid); drain & no accept -> EMPTY.
  FULL(2): in_ready=0; drain -> ONE (skid moves to main, skid cleared); otherwise hold.
- in_ready = (occupancy != 2), taken from a registered state bit. No combinational path from out_ready to in_ready.
- Ordering is strictly FIFO. The skid payload is never output before the main payload.
- Flush has priority over every other event at the same edge:
  main and skid invalid; occupancy=0.
  All data fields zeroed, except that field PC_IDX holds its previous main value so exception-PC tracing still works.
  in_valid in the same cycle is dropped.
  in_ready=1 in the next cycle.
- out_data holds its value while out_valid=0 or out_ready=0. The block never changes its data without a transfer or a flush.
- Simultaneous accept and drain in FULL cannot occur, because in_ready=0 in that state.
- Reset asserted mid-transfer: all state cleared immediately. The first valid output after reset release needs a fresh accept.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds output ports stall_cnt[31:0] and bubble_cnt[31:0].
  stall_cnt increments on each edge with in_valid=1 and in_ready=0.
  bubble_cnt increments on each edge with out_valid=0 and out_ready=1, and also on each flush that discards at least one valid payload.
  Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  field-index constants (FLD_RDATA=0, FLD_ALU=1, FLD_PC=2, FLD_INSTR=3, FLD_LO=4, FLD_HI=5);
  DEFAULT_DATA_W=32, DEFAULT_RESET_PC=32'h0000_3000;
  occupancy encoding constants OCC_EMPTY, OCC_ONE, OCC_FULL.
- One natural sub-module: pipe_stage_entry, a single valid+payload register with load, clear and keep-PC-on-clear controls. It is instantiated twice, for main and skid.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Required: out_valid=0, in_ready=1, occupancy=0, pc field=32'h0000_3000, all other fields 0.
- Streaming: out_ready=1 constant, in_valid=1 with instr=32'h0000_0001..0000_000A on consecutive cycles. Required: the same 10 values on out_data one cycle later, in_ready never 0, occupancy never 2.
- Back-pressure: out_ready=0, push A=32'h1111_1111, then B=32'h2222_2222. Required: occupancy=2 and in_ready=0. Then set out_ready=1: A is output, then B; in_ready returns to 1 after the first drain.
- Flush while FULL: flush=1 with in_valid=1 and C=32'h3333_3333. Required next cycle: out_valid=0, occupancy=0, instr field 0, pc field unchanged; C never appears on out_data.
- Async reset mid-stream: drive reset=0 between clock edges while occupancy=1. Required: out_valid falls before the next edge, and all counters and fields reach their reset values.
- PIPE_STAGE_PERF_EN build: hold in_valid=1 with out_ready=0 for 5 cycles after FULL. Required: stall_cnt=5. Then flush while occupancy=2. Required: bubble_cnt increments by 1.
